// File: rtl/tff_seq_ctrl_pkg.sv
// Shared definitions for the T-flip-flop sequencer.
//   op_e    : command opcodes carried on cmd_op
//   state_e : controller FSM states
//   WIDTH_DEF / LEN_W_DEF : default bank width and step-count width
package tff_seq_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_UP    = 2'b00,
    OP_DOWN  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/tff_seq_ctrl_if.sv
// Command channel between a command master and tff_seq_ctrl.
//   cmd_valid : command present (master -> slave)
//   cmd_ready : slave can accept this cycle (slave -> master)
//   cmd_op    : opcode (UP/DOWN/LOAD/CLEAR)
//   cmd_len   : step count for UP/DOWN
//   cmd_data  : target value for LOAD
interface tff_seq_ctrl_if
  import tff_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_len, cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_op, cmd_len, cmd_data, output cmd_ready);

endinterface

// File: rtl/tff_seq_ctrl_bank.sv
// Bank of WIDTH toggle flip-flops.
//   clk, rst : clock and synchronous active-high clear
//   t_en     : per-cell toggle enable for this edge
//   q        : current bank state
module tff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t_en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q ^ t_en;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tff_seq_ctrl.sv
// Sequencer for a bank of WIDTH T flip-flops. Accepts one command at a time
// and turns it into a per-cycle toggle vector for the bank it owns.
//   clk, rst : clock, synchronous active-high reset
//   cmd      : command channel (slave side)
//   t_en     : toggle vector applied to the bank this cycle
//   q        : current bank state
//   busy     : command in progress
//   done     : one-cycle completion pulse
//   tc       : one-cycle pulse in the cycle q first shows a wrapped value
module tff_seq_ctrl
  import tff_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  tff_seq_ctrl_if.slave    cmd,
  output logic [WIDTH-1:0] t_en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] t_run;
  logic             carry;

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk  (clk),
    .rst  (rst),
    .t_en (t_en),
    .q    (q)
  );

  // Counting toggles use a ripple term: bit i flips when all lower bits are
  // 1 (UP) or all 0 (DOWN).
  always_comb begin
    t_run = '0;
    carry = 1'b1;
    case (op_q)
      OP_UP: begin
        for (int i = 0; i < WIDTH; i++) begin
          t_run[i] = carry;
          carry    = carry & q[i];
        end
      end
      OP_DOWN: begin
        for (int i = 0; i < WIDTH; i++) begin
          t_run[i] = carry;
          carry    = carry & ~q[i];
        end
      end
      OP_LOAD:  t_run = q ^ data_q;
      default:  t_run = q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    // Registered so it lines up with the cycle the wrapped value is visible.
    tc_d    = (state_q == RUN) &&
              (((op_q == OP_UP) && (&q)) || ((op_q == OP_DOWN) && ~(|q)));
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          op_d   = cmd.cmd_op;
          data_d = cmd.cmd_data;
          if ((cmd.cmd_op == OP_LOAD) || (cmd.cmd_op == OP_CLEAR)) begin
            rem_d   = LEN_W'(1);
            state_d = RUN;
          end else begin
            rem_d   = cmd.cmd_len;
            // Zero-length count completes without touching the bank.
            state_d = (cmd.cmd_len == '0) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tc_q    <= tc_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    data_q <= data_d;
  end

  assign t_en          = (state_q == RUN) ? t_run : '0;
  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign tc            = tc_q;

endmodule
